// File: rtl/neuron_core.sv
// Integrate-and-fire neuron: saturating membrane accumulator with shift leak,
// threshold firing, refractory hold, membrane readback and a wrapping spike counter.
module neuron_core #(
  parameter int IN_W           = 16,
  parameter int ACC_W          = 22,
  parameter int LEAK_SHIFT     = 4,
  parameter int REFRACT_CYCLES = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  input_data,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             chip_sel,
  input  logic [ACC_W-1:0] threshold,
  output logic             spike,
  output logic             refractory,
  output logic [ACC_W-1:0] read_data,
  output logic             read_valid,
  output logic [CNT_W-1:0] spike_count
);

  localparam int              RC_W    = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRACT_CYCLES - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic {
    INTEG,
    REFRACT
  } state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  membrane, membrane_nxt;
  logic [RC_W-1:0]   refr_cnt, refr_cnt_nxt;
  logic              accept;
  logic              read;
  logic              fire;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  sat_sum;
  logic [ACC_W-1:0]  leak_amt;

  assign accept = chip_sel & wr_en & (state == INTEG);
  assign read   = chip_sel & rd_en;

  // One extra bit of headroom lets the carry out drive saturation directly.
  assign sum     = {1'b0, membrane} + {{(ACC_W + 1 - IN_W){1'b0}}, input_data};
  assign sat_sum = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];

  assign fire = accept & (threshold != '0) & (sat_sum >= threshold);

  // A zero shift would drain the membrane in one step, so it means no leak.
  generate
    if (LEAK_SHIFT == 0) begin : g_no_leak
      assign leak_amt = '0;
    end else begin : g_leak
      assign leak_amt = membrane >> LEAK_SHIFT;
    end
  endgenerate

  always_comb begin
    state_nxt    = state;
    membrane_nxt = membrane;
    refr_cnt_nxt = refr_cnt;
    case (state)
      INTEG: begin
        if (fire) begin
          membrane_nxt = '0;
          refr_cnt_nxt = RC_LOAD;
          state_nxt    = REFRACT;
        end else if (accept) begin
          membrane_nxt = sat_sum;
        end else begin
          membrane_nxt = membrane - leak_amt;
        end
      end
      REFRACT: begin
        membrane_nxt = '0;
        if (refr_cnt == '0) begin
          state_nxt = INTEG;
        end else begin
          refr_cnt_nxt = refr_cnt - RC_W'(1);
        end
      end
      default: begin
        state_nxt    = INTEG;
        membrane_nxt = '0;
        refr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INTEG;
      membrane    <= '0;
      refr_cnt    <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      state    <= state_nxt;
      membrane <= membrane_nxt;
      refr_cnt <= refr_cnt_nxt;
      spike    <= fire;
      if (fire) begin
        spike_count <= spike_count + CNT_W'(1);
      end
    end
  end

  // Readback captures the membrane before this cycle's update takes effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read;
      if (read) begin
        read_data <= membrane;
      end
    end
  end

  assign refractory = (state == REFRACT);

endmodule

// File: tb/tb_neuron_core.sv
// Self-checking bench for neuron_core: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_neuron_core;

  localparam int       REFRACT_CYCLES = 4;
  localparam longint   ACC_MAX        = 64'd4194303;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] input_data;
  logic        wr_en;
  logic        rd_en;
  logic        chip_sel;
  logic [21:0] threshold;
  logic        spike;
  logic        refractory;
  logic [21:0] read_data;
  logic        read_valid;
  logic [15:0] spike_count;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  longint m_mem        = 0;
  int     m_refr       = 0;
  int     exp_cnt      = 0;
  logic   exp_spike    = 1'b0;
  logic   exp_rd_valid = 1'b0;
  longint exp_rd_data  = 0;

  neuron_core dut (
    .clk        (clk),
    .rst        (rst),
    .input_data (input_data),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .chip_sel   (chip_sel),
    .threshold  (threshold),
    .spike      (spike),
    .refractory (refractory),
    .read_data  (read_data),
    .read_valid (read_valid),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  function automatic longint satAdd(input longint a, input longint b);
    return (a + b > ACC_MAX) ? ACC_MAX : a + b;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic cs, input logic [15:0] data);
    wr_en      = wr;
    rd_en      = rd;
    chip_sel   = cs;
    input_data = data;
    @(negedge clk);
  endtask

  // Reference neuron: membrane as a plain integer, refractory as cycles remaining.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mem        <= 0;
      m_refr       <= 0;
      exp_cnt      <= 0;
      exp_spike    <= 1'b0;
      exp_rd_valid <= 1'b0;
      exp_rd_data  <= 0;
    end else begin
      exp_rd_valid <= chip_sel && rd_en;
      if (chip_sel && rd_en) exp_rd_data <= m_mem;
      exp_spike <= 1'b0;
      if (m_refr > 0) begin
        m_refr <= m_refr - 1;
        m_mem  <= 0;
      end else if (chip_sel && wr_en) begin
        if (threshold != 0 && satAdd(m_mem, longint'(input_data)) >= longint'(threshold)) begin
          m_mem     <= 0;
          exp_spike <= 1'b1;
          exp_cnt   <= (exp_cnt + 1) % 65536;
          m_refr    <= REFRACT_CYCLES;
        end else begin
          m_mem <= satAdd(m_mem, longint'(input_data));
        end
      end else begin
        m_mem <= m_mem - m_mem / 16;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("spike", longint'(spike), longint'(exp_spike));
      checkOutput("refractory", longint'(refractory), (m_refr > 0) ? 1 : 0);
      checkOutput("read_valid", longint'(read_valid), longint'(exp_rd_valid));
      checkOutput("spike_count", longint'(spike_count), longint'(exp_cnt));
      if (exp_rd_valid) checkOutput("read_data", longint'(read_data), exp_rd_data);
    end
  end

  task automatic pulseReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    chip_sel   = 1'b0;
    input_data = '0;
    threshold  = 22'd1000;
    repeat (2) @(negedge clk);
    checkOutput("rst_spike", longint'(spike), 0);
    checkOutput("rst_refractory", longint'(refractory), 0);
    checkOutput("rst_read_data", longint'(read_data), 0);
    checkOutput("rst_read_valid", longint'(read_valid), 0);
    checkOutput("rst_spike_count", longint'(spike_count), 0);
    rst      = 1'b0;
    check_en = 1'b1;

    // Three sub-threshold accepts, then a firing accept with a concurrent read.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 16'd300);
    checkOutput("dir_no_spike_900", longint'(spike), 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'd300);
    checkOutput("dir_read_900", longint'(read_data), 900);
    checkOutput("dir_fire_spike", longint'(spike), 1);
    checkOutput("dir_fire_count", longint'(spike_count), 1);
    checkOutput("dir_refr_c1", longint'(refractory), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'd5000);
    checkOutput("dir_refr_ignored_read", longint'(read_data), 0);
    checkOutput("dir_refr_spike_low", longint'(spike), 0);
    checkOutput("dir_refr_c2", longint'(refractory), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("dir_refr_c3", longint'(refractory), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("dir_refr_c4", longint'(refractory), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    checkOutput("dir_refr_end", longint'(refractory), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd50);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0);
    checkOutput("dir_first_integ_50", longint'(read_data), 50);

    // Leak from 100: 94, then 89.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd100);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0);
    checkOutput("dir_leak_94", longint'(read_data), 94);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0);
    checkOutput("dir_leak_89", longint'(read_data), 89);
    checkOutput("dir_leak_valid", longint'(read_valid), 1);

    // Read and accept in the same cycle return the old membrane.
    pulseReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd40);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'd10);
    checkOutput("dir_rdacc_old_40", longint'(read_data), 40);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0);
    checkOutput("dir_rdacc_new_50", longint'(read_data), 50);

    // Firing disabled: the membrane saturates and never spikes.
    pulseReset();
    threshold = 22'd0;
    repeat (70) applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0);
    checkOutput("dir_saturate", longint'(read_data), ACC_MAX);
    checkOutput("dir_sat_no_spike_count", longint'(spike_count), 0);

    // Async reset in the middle of the refractory period.
    pulseReset();
    threshold = 22'd1000;
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd1000);
    checkOutput("dir_rst_pre_spike", longint'(spike), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("dir_rst_refr", longint'(refractory), 0);
    checkOutput("dir_rst_count", longint'(spike_count), 0);
    checkOutput("dir_rst_spike", longint'(spike), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd0);
    checkOutput("dir_post_rst_integ", longint'(read_data), 7);

    // Randomized traffic with thresholds switched periodically.
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        case ($urandom_range(0, 3))
          0:       threshold = 22'd0;
          1:       threshold = 22'($urandom_range(1, 3000));
          2:       threshold = 22'($urandom_range(3000, 200000));
          default: threshold = 22'($urandom);
        endcase
      end
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 4) != 0,
                    $urandom_range(0, 1) ? 16'($urandom_range(0, 1500)) : 16'($urandom));
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
